clock_div_multi: RTL and testbench
==================================

// Module: clock_div_multi
// PURPOSE
//   Multi-channel programmable clock divider/tick generator. It replaces the
//   fixed single-output divider.
//   Each of NUM_CH channels divides clk by a runtime-loadable ratio. It drives
//   either a 50% toggled enable-clock or a one-cycle strobe.
//   It feeds the seconds/display/debounce timing in the top level.
//   Outputs are synchronous enables in the clk domain, not for use as
//   clocks on other flops.
// PARAMETERS
//   NUM_CH       4           number of independent divider channels
//   CNT_W        32          width of each ratio register and counter
//   DEFAULT_DIV  25_000_000  ratio loaded into every channel at reset
//                            (toggle mode: 1 Hz from 50 MHz)
// PORTS
//   clk      in   1              system clock, all logic on rising edge
//   rst      in   1              asynchronous active-high reset
//   en       in   1              global count enable
//   sync_clr in   1              synchronous clear of all channel counters/outputs
//   load     in   NUM_CH         per-channel ratio load strobe
//   div_val  in   NUM_CH*CNT_W   ratio for channel i at [i*CNT_W +: CNT_W]
//   mode     in   NUM_CH         per-channel mode: 0 = toggle, 1 = pulse
//   tick     out  NUM_CH         one-cycle strobe at each terminal count
//   clk_out  out  NUM_CH         toggle mode: square wave; pulse mode: equals tick
// BEHAVIOUR
//   Reset (async, rst=1):
//     - div_reg[i] = DEFAULT_DIV; cnt[i] = 0; tick = 0; clk_out = 0.
//     - Release is sampled on the next clk edge.
//   Effective ratio R[i] = (div_reg[i] == 0) ? 1 : div_reg[i]. A zero ratio
//     behaves as 1.
//   Priority per channel per edge: sync_clr > load[i] > count.
//     - sync_clr: cnt = 0, tick = 0, clk_out = 0; div_reg retained; overrides en.
//     - load[i]: div_reg[i] <= div_val slice, cnt[i] <= 0, tick[i] <= 0.
//       clk_out[i] holds in toggle mode and is 0 in pulse mode. en is ignored
//       for the load.
//     - count (en=1):
//       - term = (cnt >= R-1); use >= so a stale cnt can never run past R.
//       - term: cnt <= 0, tick <= 1; toggle mode: clk_out <= ~clk_out;
//         pulse mode: clk_out <= 1.
//       - else: cnt <= cnt + 1, tick <= 0; pulse mode: clk_out <= 0.
//     - en=0: cnt holds; tick <= 0; toggle clk_out holds; pulse clk_out <= 0.
//   Timing: tick and clk_out are registered.
//     - Tick is high for exactly one cycle, on the R-th enabled edge after
//       reset/clr/load, then every R enabled edges.
//     - Toggle period = 2R cycles, duty 50%. Pulse period = R cycles.
//     - R=1 pulse mode: tick constantly 1 while en=1. R=1 toggle mode: clk/2.
//   Mode changes act on the next edge with no counter reset. A toggle->pulse
//     switch forces clk_out to follow tick from that edge.
//   Channels are fully independent apart from the shared en/sync_clr. A load
//     on one channel never disturbs another.
//   The counter never wraps: the maximum value is R-1 <= 2^CNT_W - 2.
//   Reset mid-count clears immediately and asynchronously, with no glitch
//     beyond the reset assertion itself.
// TESTING
//   1. Reset check: rst=1 -> tick=0, clk_out=0; after release, with en=1 and
//      no load, ch0 toggle at DEFAULT_DIV (bench overrides to 4) -> clk_out
//      toggles every 4 edges, period 8.
//   2. Load ch1 div_val=3, pulse mode -> tick[1]=1 on edges 3, 6, 9 after the
//      load; clk_out[1]==tick[1]. Other channels are unchanged in phase.
//   3. Load 0 and load 1 in pulse mode -> tick stays 1 every cycle. In toggle
//      mode -> clk_out toggles every cycle.
//   4. en low for 5 cycles mid-count (cnt=2, R=5) -> tick stays 0 and cnt
//      holds. After en returns, tick arrives 3 edges later.
//   5. sync_clr and load[0] in the same cycle -> counters clear, ch0 div_reg
//      unchanged, outputs 0. Assert rst mid-count -> outputs 0 without waiting
//      for a clk edge.
//   6. Random loads/modes/en on all channels versus a reference model ->
//      exact tick/clk_out match over 10k cycles. Check tick width is always 1
//      cycle when R>1.

Source files
------------

// File: rtl/clock_div_multi_if.sv
// Control/status bundle for the multi-channel clock divider.
// The master drives enables, clears, ratio loads and modes; the slave
// returns the per-channel tick strobes and enable-clocks.
interface clock_div_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  logic                      en;
  logic                      sync_clr;
  logic [NUM_CH-1:0]         load;
  logic [NUM_CH*CNT_W-1:0]   div_val;
  logic [NUM_CH-1:0]         mode;
  logic [NUM_CH-1:0]         tick;
  logic [NUM_CH-1:0]         clk_out;

  modport master (
    output en, sync_clr, load, div_val, mode,
    input  tick, clk_out
  );

  modport slave (
    input  en, sync_clr, load, div_val, mode,
    output tick, clk_out
  );
endinterface

// File: rtl/clock_div_multi.sv
// Multi-channel programmable divider / tick generator.
// Each channel counts enabled clk edges up to its ratio R and then emits a
// one-cycle tick. In toggle mode (mode=0) clk_out flips at every tick,
// giving a 2R-cycle square wave; in pulse mode (mode=1) clk_out mirrors
// tick. A programmed ratio of 0 behaves as 1. Outputs are clk-domain
// enables, not clocks.
module clock_div_multi #(
  parameter int               NUM_CH      = 4,
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(25_000_000)
) (
  input  logic               clk,
  input  logic               rst,
  clock_div_multi_if.slave   bus
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] r_m1;
    logic             term;
    logic             tick_q;
    logic             clk_out_q;
    logic [CNT_W-1:0] div_slice;

    assign div_slice = bus.div_val[i*CNT_W +: CNT_W];

    // Terminal count at R-1 (zero ratio folds to R=1); >= guards against a
    // counter that is somehow past the current ratio.
    assign r_m1 = (div_reg == '0) ? '0 : div_reg - 1'b1;
    assign term = (cnt >= r_m1);

    // Per-channel counter and registered outputs: sync_clr > load > count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        div_reg   <= DEFAULT_DIV;
        cnt       <= '0;
        tick_q    <= 1'b0;
        clk_out_q <= 1'b0;
      end else if (bus.sync_clr) begin
        cnt       <= '0;
        tick_q    <= 1'b0;
        clk_out_q <= 1'b0;
      end else if (bus.load[i]) begin
        div_reg <= div_slice;
        cnt     <= '0;
        tick_q  <= 1'b0;
        if (bus.mode[i]) begin
          clk_out_q <= 1'b0;
        end
      end else if (bus.en) begin
        if (term) begin
          cnt    <= '0;
          tick_q <= 1'b1;
          if (bus.mode[i]) begin
            clk_out_q <= 1'b1;
          end else begin
            clk_out_q <= ~clk_out_q;
          end
        end else begin
          cnt    <= cnt + 1'b1;
          tick_q <= 1'b0;
          if (bus.mode[i]) begin
            clk_out_q <= 1'b0;
          end
        end
      end else begin
        tick_q <= 1'b0;
        if (bus.mode[i]) begin
          clk_out_q <= 1'b0;
        end
      end
    end

    assign bus.tick[i]    = tick_q;
    assign bus.clk_out[i] = clk_out_q;
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// Bench for clock_div_multi: directed scenarios with literal expectations
// plus a long randomised run, all cross-checked against a behavioural model
// that tracks "enabled edges since last restart" and decides ticks by
// modulo arithmetic on the effective ratio.
module tb_clock_div_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int DEF    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clock_div_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clock_div_multi #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_DIV(CNT_W'(DEF))
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  longint            m_div [NUM_CH];
  longint            m_n   [NUM_CH];
  logic [NUM_CH-1:0] m_tick;
  logic [NUM_CH-1:0] m_lvl;

  task automatic chk(input string name, input logic [NUM_CH-1:0] act,
                     input logic [NUM_CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  // Reference model: ticks land on every R-th enabled edge since restart.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < NUM_CH; i++) begin
          m_div[i] = DEF;
          m_n[i]   = 0;
        end
        m_tick = '0;
        m_lvl  = '0;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          longint r;
          r = (m_div[i] < 1) ? 1 : m_div[i];
          if (bus.sync_clr) begin
            m_n[i] = 0; m_tick[i] = 1'b0; m_lvl[i] = 1'b0;
          end else if (bus.load[i]) begin
            m_div[i] = longint'(bus.div_val[i*CNT_W +: CNT_W]);
            m_n[i] = 0; m_tick[i] = 1'b0;
            if (bus.mode[i]) m_lvl[i] = 1'b0;
          end else if (bus.en) begin
            m_n[i]++;
            m_tick[i] = ((m_n[i] % r) == 0);
            if (bus.mode[i]) m_lvl[i] = m_tick[i];
            else if (m_tick[i]) m_lvl[i] = ~m_lvl[i];
          end else begin
            m_tick[i] = 1'b0;
            if (bus.mode[i]) m_lvl[i] = 1'b0;
          end
        end
      end
    end
  end

  // Compare DUT against the model shortly after every active edge.
  logic [NUM_CH-1:0] prev_tick = '0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        checks++;
        if (bus.tick !== m_tick || bus.clk_out !== m_lvl) begin
          failures++;
          if (failures < 20)
            $display("FAIL model_cmp t=%0t tick=%b clk_out=%b required tick=%b clk_out=%b",
                     $time, bus.tick, bus.clk_out, m_tick, m_lvl);
        end
        for (int i = 0; i < NUM_CH; i++) begin
          if (prev_tick[i] && m_div[i] > 1) begin
            checks++;
            if (bus.tick[i] !== 1'b0) begin
              failures++;
              if (failures < 20)
                $display("FAIL tick_width ch=%0d t=%0t actual=%b required=0",
                         i, $time, bus.tick[i]);
            end
          end
        end
        prev_tick = bus.tick;
      end else begin
        prev_tick = '0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    bus.en = 1'b0; bus.sync_clr = 1'b0; bus.load = '0;
    bus.div_val = '0; bus.mode = '0;

    // Reset state
    #12;
    chk("rst_tick", bus.tick, '0);
    chk("rst_clk_out", bus.clk_out, '0);
    @(negedge clk);
    rst = 1'b0; bus.en = 1'b1;

    // 1: default ratio 4, toggle mode
    for (int e = 1; e <= 9; e++) begin
      step();
      chk("t1_clk_out0", bus.clk_out[0], (e >= 4 && e < 8));
      chk("t1_tick0", bus.tick[0], (e == 4 || e == 8));
    end

    // 2: ch1 ratio 3 pulse mode; ch0 keeps its phase
    bus.load = 4'b0010; bus.div_val[CNT_W +: CNT_W] = 3; bus.mode[1] = 1'b1;
    step();
    bus.load = '0;
    chk("t2_load_tick1", bus.tick[1], 1'b0);
    for (int e = 1; e <= 9; e++) begin
      step();
      chk("t2_tick1", bus.tick[1], (e % 3 == 0));
      chk("t2_clk_out1", bus.clk_out[1], (e % 3 == 0));
      chk("t2_ch0_tick", bus.tick[0], ((10 + e) % 4 == 0));
    end

    // 3: ratio 0 pulse and ratio 1 toggle
    bus.sync_clr = 1'b1;
    step();
    bus.sync_clr = 1'b0;
    chk("t3_clr_tick", bus.tick, '0);
    chk("t3_clr_clk_out", bus.clk_out, '0);
    bus.load = 4'b1100; bus.mode[2] = 1'b1; bus.mode[3] = 1'b0;
    bus.div_val[2*CNT_W +: CNT_W] = 0; bus.div_val[3*CNT_W +: CNT_W] = 1;
    step();
    bus.load = '0;
    chk("t3_load_tick2", bus.tick[2], 1'b0);
    chk("t3_load_clk_out3", bus.clk_out[3], 1'b0);
    for (int e = 1; e <= 6; e++) begin
      step();
      chk("t3_tick2", bus.tick[2], 1'b1);
      chk("t3_clk_out2", bus.clk_out[2], 1'b1);
      chk("t3_clk_out3", bus.clk_out[3], (e % 2 == 1));
    end

    // 4: ch0 ratio 5, pause at cnt=2 for 5 cycles
    bus.load = 4'b0001; bus.div_val[0 +: CNT_W] = 5; bus.mode[0] = 1'b0;
    step();
    bus.load = '0;
    step(); step();
    bus.en = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("t4_paused_tick", bus.tick, '0);
    end
    bus.en = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk("t4_resume_tick0", bus.tick[0], (e == 3));
    end

    // 5: sync_clr beats load[0]; ch0 keeps ratio 5
    bus.sync_clr = 1'b1; bus.load = 4'b0001; bus.div_val[0 +: CNT_W] = 7;
    step();
    bus.sync_clr = 1'b0; bus.load = '0;
    chk("t5_clr_tick", bus.tick, '0);
    chk("t5_clr_clk_out", bus.clk_out, '0);
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("t5_tick0", bus.tick[0], (e == 5));
      chk("t5_tick1", bus.tick[1], (e == 3));
    end
    step();
    chk("t5_pre_rst_tick2", bus.tick[2], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_tick", bus.tick, '0);
    chk("t5_async_clk_out", bus.clk_out, '0);
    @(negedge clk);
    rst = 1'b0;

    // 6: randomised traffic against the model
    for (int c = 0; c < 10000; c++) begin
      step();
      bus.en = ($urandom_range(9) != 0);
      bus.sync_clr = ($urandom_range(199) == 0);
      bus.load = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if ($urandom_range(15) == 0) begin
          bus.load[ch] = 1'b1;
          bus.div_val[ch*CNT_W +: CNT_W] = CNT_W'($urandom_range(6));
        end
        if ($urandom_range(31) == 0) bus.mode[ch] = ~bus.mode[ch];
      end
    end
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
